// File: rtl/hazard_stall_controller.sv
// Stall, bubble and flush sequencing for the five-stage pipeline, plus the
// mult/div occupancy FSM. Optional perf counter: HAZARD_PERF_CNT_EN.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   id_rs/id_rt         ID source registers; id_uses_rs/rt qualify them
//   id_muldiv           ID holds MULT/MULTU/DIV/DIVU
//   id_reads_hilo       ID holds MFHI/MFLO
//   ex_mem_read, ex_rd  EX load flag and destination register
//   ex_branch_taken     EX branch/jump resolved taken
//   mem_stall           memory not ready, freeze everything
//   pc_we..memwb_we     PC / pipeline register write enables
//   ifid_flush          clear IF/ID
//   idex_bubble         load NOP into ID/EX
//   md_start, md_busy   mult/div start pulse and occupancy
//   stall_cycles        count of cycles with pc_we=0 (0 when counter disabled)
module hazard_stall_controller #(
  parameter int MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_stall,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] LAT = 8'(MULDIV_LAT);

  state_t     r_state;
  logic [7:0] r_md_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_load_use;
  logic       w_md_haz;
  logic       w_id_stall;

  // $zero is never a real dependency
  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (ex_rd == id_rs)) ||
                       (id_uses_rt && (ex_rd == id_rt)));

  assign w_md_haz   = (r_state == MD_BUSY) &&
                      (id_reads_hilo || id_muldiv);

  assign w_id_stall = w_load_use || w_md_haz;

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst || mem_stall) begin
      // frozen: everything stays low
    end else if (ex_branch_taken) begin
      // ID is wrong-path, so its stall is irrelevant
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_id_stall) begin
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
    end
  end

  assign md_start = !rst && !mem_stall && !ex_branch_taken &&
                    !w_load_use && id_muldiv && (r_state == RUN);

  assign md_busy  = (r_md_cnt != 8'd0);

  // a running op only pauses on memory freeze, never on flush
  always_comb begin
    w_cnt_nxt = r_md_cnt;
    if (md_start)
      w_cnt_nxt = LAT;
    else if ((r_md_cnt != 8'd0) && !mem_stall)
      w_cnt_nxt = r_md_cnt - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= 8'd0;
    end else begin
      r_md_cnt <= w_cnt_nxt;
      r_state  <= (w_cnt_nxt != 8'd0) ? MD_BUSY : RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= 32'd0;
    else if (!pc_we && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences pipeline stalls, bubbles and flushes for the five-stage MIPS pipeline, alongside the forwarding unit that resolves EX/MEM-to-EX data hazards. Covers the cases forwarding cannot:
- load-use hazards
- reads of HI/LO or back-to-back mult/div while the multi-cycle multiply/divide unit is busy
- taken-branch wrong-path squash
- global freezes on memory wait

It owns the multiply/divide occupancy state machine and drives the write enables of PC and all pipeline registers.

## Interface
Parameters:
- MULDIV_LAT, 32, busy cycles of the mult/div unit after start (2..255)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- id_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_stall  in  1  data/instruction memory not ready
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register write enables
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_busy  out  1  mult/div unit occupied
- stall_cycles  out  32  perf counter (see Configuration)

## Operation
- Enable and control outputs are combinational from the registered state and the current inputs. State register is {state, md_cnt[7:0]}.
- FSM states:
  - RUN: md_cnt == 0.
  - MD_BUSY: md_cnt != 0.
- Conditions evaluated each cycle, highest priority first:
  1. mem_stall: all five write enables 0; flush, bubble and md_start 0; md_cnt holds.
  2. ex_branch_taken: pc_we=1, ifid_flush=1, idex_bubble=1, other enables 1, md_start=0. Overrides any ID-side stall, because the ID instruction is wrong-path.
  3. Load-use: ex_mem_read && ex_rd != 0 && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt)). Then pc_we=0, ifid_we=0, idex_bubble=1, downstream enables 1.
  4. MD hazard: state MD_BUSY && (id_reads_hilo || id_muldiv). Same outputs as load-use.
  5. Normal: all enables 1, flush/bubble 0.
- md_start = 1 only when id_muldiv, state RUN, and none of conditions 1–3 apply.
- On the md_start edge, md_cnt loads MULDIV_LAT.
- In MD_BUSY, md_cnt decrements by 1 on each clk edge where mem_stall=0. Reaching 0 returns to RUN.
- md_busy = (md_cnt != 0).
- A started mult/div is never cancelled by a branch flush; it is older than the branch.
- Register $zero (ex_rd == 0) never causes a load-use stall.

## Timing
- Stall/flush decisions take effect in the same cycle as the condition (0-cycle latency).
- Load-use stall lasts exactly 1 cycle if the load advances normally.
- md_start asserted in cycle N → md_busy is high for cycles N+1 .. N+MULDIV_LAT, plus one cycle per mem_stall cycle in that window. A dependent MFHI/MFLO held in ID issues in the first cycle md_busy=0.
- While rst=1, asynchronously:
  - all write enables 0, ifid_flush 0, idex_bubble 0, md_start 0, md_busy 0
  - md_cnt 0, state RUN, stall_cycles 0
- Reset mid-MD_BUSY abandons the operation immediately.
- First cycle after rst deasserts: normal RUN behaviour.
- Simultaneous ex_branch_taken and mem_stall: freeze wins. The flush applies on the first cycle mem_stall is low, provided ex_branch_taken is still asserted (EX is frozen, so it is).

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on each clk edge where rst=0 and pc_we=0.
  - Saturates at 32'hFFFF_FFFF; cleared only by rst.
- HAZARD_PERF_CNT_EN undefined: stall_cycles is tied to 0, no counter flops are built; all other behaviour is identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle → that cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle (ex_mem_read=0) all enables 1. Repeat with ex_rd=0 → no stall.
- Mult/div occupancy, MULDIV_LAT=4: id_muldiv=1 in cycle 0 → md_start=1 in cycle 0. Hold id_reads_hilo=1 from cycle 1 → md_busy=1 and pc_we=0 for cycles 1–4; cycle 5 md_busy=0, pc_we=1.
- Back-to-back mult/div: second id_muldiv while MD_BUSY → stalled with no md_start until md_busy falls, then md_start=1 that cycle.
- Branch over stall: in MD_BUSY with id_reads_hilo=1, assert ex_branch_taken → pc_we=1, ifid_flush=1, idex_bubble=1; md_busy stays 1 and md_cnt keeps counting.
- Memory freeze: MULDIV_LAT=4, mem_stall=1 for 2 cycles starting cycle 2 → all enables 0 in those cycles; md_busy high for cycles 1–6. With HAZARD_PERF_CNT_EN, stall_cycles counts every pc_we=0 cycle.
- Async reset: assert rst mid-MD_BUSY (between edges) → md_busy=0 and all enables 0 immediately; after release, id_reads_hilo issues with no stall.
